// File: rtl/module_keypad_calc.sv
// -----------------------------------------------------------------------------
// module_keypad_calc
// Upstream stage of the 7-segment display controller. Debounced key codes from
// the keypad scanner build two decimal operands; '=' combines them. The operand
// being typed, or the final result, is presented as a binary value together
// with a level valid that the display latches on its rising edge.
//
// Optional feature macro: CALC_SUB_EN
//   defined   : KEY_SUB selects subtraction, '=' gives |A-B| and neg=(A<B)
//   undefined : KEY_SUB is ignored and neg stays 0
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous reset, active low
//   key_code      in   [3:0] key code (0-9 digits, others per parameters)
//   key_valid     in   one-cycle strobe qualifying key_code
//   disp_busy     in   display converting; no service, no new valid edge
//   result_out    out  [RESULT_WIDTH-1:0] value to display (<= 9999)
//   result_valid  out  level; rising edge marks a new result_out
//   ovf           out  result clamped to 9999
//   neg           out  result is |A-B| with A<B
// -----------------------------------------------------------------------------
module module_keypad_calc #(
  parameter int unsigned RESULT_WIDTH = 14,
  parameter int unsigned DIGITS_MAX   = 3,
  parameter logic [3:0]  KEY_ADD      = 4'hA,
  parameter logic [3:0]  KEY_SUB      = 4'hB,
  parameter logic [3:0]  KEY_CLR      = 4'hC,
  parameter logic [3:0]  KEY_EQ       = 4'hE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              key_code,
  input  logic                    key_valid,
  input  logic                    disp_busy,
  output logic [RESULT_WIDTH-1:0] result_out,
  output logic                    result_valid,
  output logic                    ovf,
  output logic                    neg
);

  localparam int unsigned CW = $clog2(DIGITS_MAX + 1);
  localparam logic [RESULT_WIDTH-1:0] VAL_MAX = RESULT_WIDTH'(14'd9999);

  typedef enum logic [1:0] {
    S_OPA  = 2'd0,
    S_OPB  = 2'd1,
    S_SHOW = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [RESULT_WIDTH-1:0] opa_q, opa_d;
  logic [RESULT_WIDTH-1:0] opb_q, opb_d;
  logic [RESULT_WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    sub_q, sub_d;
  logic                    ovf_q, ovf_d;
  logic                    neg_q, neg_d;
  logic                    pend_q, pend_d;
  logic [RESULT_WIDTH-1:0] pend_val_q, pend_val_d;
  logic [RESULT_WIDTH-1:0] result_out_q, result_out_d;
  logic                    result_valid_q, result_valid_d;
  logic                    arm_q, arm_d;

  logic                    is_digit_s;
  logic                    is_sub_s;
  logic                    is_op_s;
  logic                    cnt_full_s;
  logic [CW-1:0]           cnt_inc_s;
  logic [RESULT_WIDTH-1:0] digit_s;
  logic [RESULT_WIDTH-1:0] opa_app_s;
  logic [RESULT_WIDTH-1:0] opb_app_s;
  logic [RESULT_WIDTH:0]   sum_s;
  logic [RESULT_WIDTH-1:0] diff_s;
  logic                    a_lt_b_s;
  logic                    upd_s;
  logic [RESULT_WIDTH-1:0] upd_val_s;
  logic                    req_s;
  logic [RESULT_WIDTH-1:0] req_val_s;

  // Key decode and the arithmetic shared by the state machine.
  always_comb begin
    is_digit_s = (key_code <= 4'd9);
`ifdef CALC_SUB_EN
    is_sub_s   = (key_code == KEY_SUB);
`else
    is_sub_s   = (key_code == KEY_SUB) & 1'b0;
`endif
    is_op_s    = (key_code == KEY_ADD) | is_sub_s;
    cnt_full_s = (cnt_q == CW'(DIGITS_MAX));
    cnt_inc_s  = cnt_q + CW'(1'b1);
    digit_s    = RESULT_WIDTH'(key_code);
    opa_app_s  = (opa_q * RESULT_WIDTH'(4'd10)) + digit_s;
    opb_app_s  = (opb_q * RESULT_WIDTH'(4'd10)) + digit_s;
    sum_s      = {1'b0, opa_q} + {1'b0, opb_q};
    a_lt_b_s   = (opa_q < opb_q);
    if (a_lt_b_s) begin
      diff_s = opb_q - opa_q;
    end else begin
      diff_s = opa_q - opb_q;
    end
  end

  // Calculator state machine: one key per strobe, clear has top priority.
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    sub_d     = sub_q;
    ovf_d     = ovf_q;
    neg_d     = neg_q;
    upd_s     = 1'b0;
    upd_val_s = '0;
    if (key_valid) begin
      if (key_code == KEY_CLR) begin
        state_d = S_OPA;
        opa_d   = '0;
        opb_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        neg_d   = 1'b0;
        upd_s   = 1'b1;
      end else begin
        case (state_q)
          S_OPA: begin
            if (is_digit_s) begin
              if (!cnt_full_s) begin
                opa_d     = opa_app_s;
                cnt_d     = cnt_inc_s;
                ovf_d     = 1'b0;
                neg_d     = 1'b0;
                upd_s     = 1'b1;
                upd_val_s = opa_app_s;
              end else begin
                cnt_d = cnt_q;
              end
            end else if (is_op_s && (cnt_q != '0)) begin
              // Display keeps showing opA until the first opB digit.
              opb_d   = '0;
              cnt_d   = '0;
              sub_d   = is_sub_s;
              state_d = S_OPB;
            end else begin
              state_d = state_q;
            end
          end
          S_OPB: begin
            if (is_digit_s) begin
              if (!cnt_full_s) begin
                opb_d     = opb_app_s;
                cnt_d     = cnt_inc_s;
                ovf_d     = 1'b0;
                neg_d     = 1'b0;
                upd_s     = 1'b1;
                upd_val_s = opb_app_s;
              end else begin
                cnt_d = cnt_q;
              end
            end else if ((key_code == KEY_EQ) && (cnt_q != '0)) begin
              state_d = S_SHOW;
              upd_s   = 1'b1;
              if (sub_q) begin
                res_d     = diff_s;
                neg_d     = a_lt_b_s;
                ovf_d     = 1'b0;
                upd_val_s = diff_s;
              end else if (sum_s > {1'b0, VAL_MAX}) begin
                // Only a chained operand can push the sum past four digits.
                res_d     = VAL_MAX;
                ovf_d     = 1'b1;
                upd_val_s = VAL_MAX;
              end else begin
                res_d     = sum_s[RESULT_WIDTH-1:0];
                ovf_d     = 1'b0;
                upd_val_s = sum_s[RESULT_WIDTH-1:0];
              end
            end else begin
              state_d = state_q;
            end
          end
          S_SHOW: begin
            if (is_digit_s) begin
              opa_d     = digit_s;
              cnt_d     = CW'(1'b1);
              ovf_d     = 1'b0;
              neg_d     = 1'b0;
              state_d   = S_OPA;
              upd_s     = 1'b1;
              upd_val_s = digit_s;
            end else if (is_op_s) begin
              // Chain: the stored magnitude becomes opA, sign is dropped.
              opa_d   = res_q;
              opb_d   = '0;
              cnt_d   = '0;
              sub_d   = is_sub_s;
              state_d = S_OPB;
            end else begin
              state_d = state_q;
            end
          end
          default: begin
            state_d = S_OPA;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Display update engine: newest request wins; valid rises one cycle after load.
  always_comb begin
    result_out_d   = result_out_q;
    result_valid_d = result_valid_q;
    arm_d          = arm_q;
    pend_d         = pend_q;
    pend_val_d     = pend_val_q;
    req_s          = upd_s | pend_q;
    if (upd_s) begin
      req_val_s = upd_val_s;
    end else begin
      req_val_s = pend_val_q;
    end
    if (req_s && !disp_busy) begin
      result_out_d   = req_val_s;
      result_valid_d = 1'b0;
      arm_d          = 1'b1;
      pend_d         = 1'b0;
    end else if (req_s) begin
      pend_d     = 1'b1;
      pend_val_d = req_val_s;
    end else if (arm_q && !disp_busy) begin
      result_valid_d = 1'b1;
      arm_d          = 1'b0;
    end else begin
      arm_d = arm_q;
    end
  end

  // State registers; reset leaves a pending request so '0' gets displayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_OPA;
      opa_q          <= '0;
      opb_q          <= '0;
      res_q          <= '0;
      cnt_q          <= '0;
      sub_q          <= 1'b0;
      ovf_q          <= 1'b0;
      neg_q          <= 1'b0;
      pend_q         <= 1'b1;
      pend_val_q     <= '0;
      result_out_q   <= '0;
      result_valid_q <= 1'b0;
      arm_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      res_q          <= res_d;
      cnt_q          <= cnt_d;
      sub_q          <= sub_d;
      ovf_q          <= ovf_d;
      neg_q          <= neg_d;
      pend_q         <= pend_d;
      pend_val_q     <= pend_val_d;
      result_out_q   <= result_out_d;
      result_valid_q <= result_valid_d;
      arm_q          <= arm_d;
    end
  end

  assign result_out   = result_out_q;
  assign result_valid = result_valid_q;
  assign ovf          = ovf_q;
  assign neg          = neg_q;

endmodule
